// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared constants and types for the data-memory responder.
//               Covers the MMIO base, the register offsets, the MMIO
//               selector enum and the STAT bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Address bit 31 selects MMIO. Everything below it selects word RAM.
  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

  // Word offsets inside the MMIO block, taken from address bits [4:2].
  localparam logic [2:0] OFS_LED   = 3'd0;
  localparam logic [2:0] OFS_CYCLE = 3'd1;
  localparam logic [2:0] OFS_CMP   = 3'd2;
  localparam logic [2:0] OFS_STAT  = 3'd3;
  localparam logic [2:0] OFS_BTN   = 3'd4;

  typedef enum logic [2:0] {
    SEL_LED   = 3'd0,
    SEL_CYCLE = 3'd1,
    SEL_CMP   = 3'd2,
    SEL_STAT  = 3'd3,
    SEL_BTN   = 3'd4,
    SEL_NONE  = 3'd7
  } mmio_sel_e;

  // STAT register bit positions.
  localparam int STAT_MATCH_BIT = 0;
  localparam int STAT_UNMAP_BIT = 1;

  // Map a word offset to a register selector. Offsets 5..7 are unmapped.
  function automatic mmio_sel_e decode_ofs(input logic [2:0] ofs);
    case (ofs)
      OFS_LED:   return SEL_LED;
      OFS_CYCLE: return SEL_CYCLE;
      OFS_CMP:   return SEL_CMP;
      OFS_STAT:  return SEL_STAT;
      OFS_BTN:   return SEL_BTN;
      default:   return SEL_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ram
// Description : DEPTH x 32 word RAM. Reads are asynchronous and writes are
//               synchronous. The contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ram #(
  parameter int    DEPTH     = 256,
  parameter int    AW        = $clog2(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Synchronous write port. A read of the same word returns the old data
  // until the next cycle.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Zero-latency read path for the single-cycle core.
  assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for the core. Decodes each address to
//               either word RAM or MMIO. The MMIO block holds the LED, CYCLE,
//               CMP, STAT and BTN registers. Reads are combinational and
//               writes land at posedge clk.
//               Optional feature macro: DMEM_TIMER_EN enables the compare
//               timer, which adds CMP, STAT.bit0 and timer_irq.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int    RAM_DEPTH = 256,
  parameter int    LED_W     = 6,
  parameter int    BTN_W     = 2,
  parameter string INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dmem_Write,
  input  logic [31:0]      dmem_Addr,
  input  logic [31:0]      dmem_WriteData,
  output logic [31:0]      dmem_ReadData,
  input  logic [BTN_W-1:0] btn,
  output logic [LED_W-1:0] led,
  output logic             timer_irq
);

  localparam int AW = $clog2(RAM_DEPTH);

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic      is_mmio;
  mmio_sel_e sel;
  logic      wr_mmio;
  logic      ram_we;
  logic      unmapped;
  logic      addr_unused;

  assign is_mmio  = (dmem_Addr & MMIO_BASE) == MMIO_BASE;
  assign sel      = decode_ofs(dmem_Addr[4:2]);
  assign unmapped = is_mmio && (sel == SEL_NONE);
  // A write during reset is dropped entirely, for both the RAM and the registers.
  assign wr_mmio  = rst && dmem_Write && is_mmio;
  assign ram_we   = rst && dmem_Write && !is_mmio;

  // The byte-lane bits and the address bits above the RAM index take no part in decode.
  assign addr_unused = ^{dmem_Addr[1:0], dmem_Addr[30:AW+2]};

  // --------------------------------------------------------------------------
  // Word RAM
  // --------------------------------------------------------------------------
  logic [31:0] ram_rdata;

  dmem_ram #(
    .DEPTH     (RAM_DEPTH),
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (dmem_Addr[AW+1:2]),
    .wdata_i (dmem_WriteData),
    .rdata_o (ram_rdata)
  );

  // --------------------------------------------------------------------------
  // MMIO registers
  // --------------------------------------------------------------------------
  logic [LED_W-1:0] led_q,   led_d;
  logic [31:0]      cycle_q, cycle_d;
  logic [1:0]       stat_q,  stat_d;
  logic [BTN_W-1:0] sync1_q, sync2_q;
  logic             match;

`ifdef DMEM_TIMER_EN
  logic [31:0]      cmp_q,   cmp_d;

  // The compare uses the CYCLE and CMP values from before this cycle's update.
  assign match = (cycle_q == cmp_q);
`else
  assign match = 1'b0;
`endif

  // Next-state logic for every MMIO register.
  always_comb begin
    led_d   = led_q;
    cycle_d = cycle_q + 32'd1;
    stat_d  = stat_q;
`ifdef DMEM_TIMER_EN
    cmp_d   = cmp_q;
`endif

    if (wr_mmio && (sel == SEL_LED)) begin
      led_d = dmem_WriteData[LED_W-1:0];
    end

    // A load replaces the increment for that cycle.
    if (wr_mmio && (sel == SEL_CYCLE)) begin
      cycle_d = dmem_WriteData;
    end

`ifdef DMEM_TIMER_EN
    if (wr_mmio && (sel == SEL_CMP)) begin
      cmp_d = dmem_WriteData;
    end
`endif

    // Writing 1 clears a bit. The set terms come afterwards, so a set in the
    // same cycle as a clear wins.
    if (wr_mmio && (sel == SEL_STAT)) begin
      stat_d = stat_q & ~dmem_WriteData[1:0];
    end
    if (unmapped) begin
      stat_d[STAT_UNMAP_BIT] = 1'b1;
    end
    if (match) begin
      stat_d[STAT_MATCH_BIT] = 1'b1;
    end
  end

  // Register update with a synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      led_q   <= '0;
      cycle_q <= '0;
      stat_q  <= '0;
`ifdef DMEM_TIMER_EN
      cmp_q   <= 32'hFFFF_FFFF;
`endif
    end else begin
      led_q   <= led_d;
      cycle_q <= cycle_d;
      stat_q  <= stat_d;
`ifdef DMEM_TIMER_EN
      cmp_q   <= cmp_d;
`endif
    end
  end

  // Two-flop synchronizer for the asynchronous button pins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Read mux: zero-latency. It returns values from before any write in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    dmem_ReadData = 32'h0;
    if (!is_mmio) begin
      dmem_ReadData = ram_rdata;
    end else begin
      case (sel)
        SEL_LED:   dmem_ReadData = {{(32-LED_W){1'b0}}, led_q};
        SEL_CYCLE: dmem_ReadData = cycle_q;
`ifdef DMEM_TIMER_EN
        SEL_CMP:   dmem_ReadData = cmp_q;
`else
        SEL_CMP:   dmem_ReadData = 32'h0;
`endif
        SEL_STAT:  dmem_ReadData = {30'h0, stat_q};
        SEL_BTN:   dmem_ReadData = {{(32-BTN_W){1'b0}}, sync2_q};
        default:   dmem_ReadData = 32'h0;
      endcase
    end
  end

  assign led       = led_q;
  assign timer_irq = stat_q[STAT_MATCH_BIT];

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder. It covers
//               reset state, RAM, LED, CYCLE, the timer, unmapped accesses,
//               BTN, and reset during a write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

`ifdef DMEM_TIMER_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  localparam logic [31:0] A_LED   = 32'h8000_0000;
  localparam logic [31:0] A_CYCLE = 32'h8000_0004;
  localparam logic [31:0] A_CMP   = 32'h8000_0008;
  localparam logic [31:0] A_STAT  = 32'h8000_000C;
  localparam logic [31:0] A_BTN   = 32'h8000_0010;

  logic        clk;
  logic        rst;
  logic        dmem_Write;
  logic [31:0] dmem_Addr;
  logic [31:0] dmem_WriteData;
  logic [31:0] dmem_ReadData;
  logic [1:0]  btn;
  logic [5:0]  led;
  logic        timer_irq;

  int errors = 0;
  int checks = 0;

  dmem_responder dut (
    .clk            (clk),
    .rst            (rst),
    .dmem_Write     (dmem_Write),
    .dmem_Addr      (dmem_Addr),
    .dmem_WriteData (dmem_WriteData),
    .dmem_ReadData  (dmem_ReadData),
    .btn            (btn),
    .led            (led),
    .timer_irq      (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one access and let the combinational read path settle.
  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
    dmem_Write     = w;
    dmem_Addr      = a;
    dmem_WriteData = d;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    btn = 2'b00;
    drive(1'b0, 32'h0, 32'h0);

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_led", {26'h0, led}, 32'h0);
    check("rst_irq", {31'h0, timer_irq}, 32'h0);
    drive(1'b0, A_LED, 32'h0);
    check("rst_led_rd", dmem_ReadData, 32'h0);
    drive(1'b0, A_CMP, 32'h0);
    check("rst_cmp_rd", dmem_ReadData, TEN ? 32'hFFFF_FFFF : 32'h0);
    drive(1'b0, A_CYCLE, 32'h0);
    check("rst_cycle_rd", dmem_ReadData, 32'h0);
    drive(1'b0, A_STAT, 32'h0);
    check("rst_stat_rd", dmem_ReadData, 32'h0);

    // ---------------- RAM write/read/alias ----------------
    rst = 1'b1;
    drive(1'b1, 32'h10, 32'h1111_1111);
    tick();
    drive(1'b1, 32'h10, 32'hDEAD_BEEF);
    check("ram_same_cycle_old", dmem_ReadData, 32'h1111_1111);
    tick();
    drive(1'b0, 32'h10, 32'h0);
    check("ram_next_cycle", dmem_ReadData, 32'hDEAD_BEEF);
    drive(1'b0, 32'h10 + 4 * 256, 32'h0);
    check("ram_alias", dmem_ReadData, 32'hDEAD_BEEF);

    // ---------------- LED ----------------
    drive(1'b1, A_LED, 32'hFFFF_FFA5);
    check("led_same_cycle_old", dmem_ReadData, 32'h0);
    tick();
    drive(1'b0, A_LED, 32'h0);
    check("led_pin", {26'h0, led}, 32'h25);
    check("led_rd", dmem_ReadData, 32'h25);

    // ---------------- CYCLE load and wrap ----------------
    drive(1'b1, A_CYCLE, 32'hFFFF_FFFE);
    tick();
    drive(1'b0, A_CYCLE, 32'h0);
    check("cycle_load", dmem_ReadData, 32'hFFFF_FFFE);
    tick();
    check("cycle_max", dmem_ReadData, 32'hFFFF_FFFF);
    check("irq_before_wrap_match", {31'h0, timer_irq}, 32'h0);
    tick();
    check("cycle_wrap", dmem_ReadData, 32'h0);
    // CYCLE passed through 0xFFFF_FFFF while CMP still held its reset value.
    check("irq_reset_cmp_match", {31'h0, timer_irq}, {31'h0, TEN});
    drive(1'b1, A_STAT, 32'h1);
    tick();
    check("irq_cleared", {31'h0, timer_irq}, 32'h0);

    // ---------------- compare timer ----------------
    drive(1'b1, A_CYCLE, 32'd10);
    tick();
    drive(1'b1, A_CMP, 32'd20);
    check("cmp_same_cycle_old", dmem_ReadData, TEN ? 32'hFFFF_FFFF : 32'h0);
    tick();
    drive(1'b0, A_CMP, 32'h0);
    check("cmp_rd", dmem_ReadData, TEN ? 32'd20 : 32'h0);
    drive(1'b0, A_CYCLE, 32'h0);
    check("cycle_after_cmp_wr", dmem_ReadData, 32'd11);
    repeat (9) tick();
    check("cycle_at_match", dmem_ReadData, 32'd20);
    check("irq_not_yet", {31'h0, timer_irq}, 32'h0);
    // Clear request on the match cycle: the set must win.
    drive(1'b1, A_STAT, 32'h1);
    tick();
    check("irq_set_wins", {31'h0, timer_irq}, {31'h0, TEN});
    drive(1'b0, A_STAT, 32'h0);
    check("stat_match_rd", dmem_ReadData, {31'h0, TEN});
    drive(1'b1, A_STAT, 32'h1);
    tick();
    check("irq_clear", {31'h0, timer_irq}, 32'h0);

    // ---------------- unmapped ----------------
    drive(1'b0, 32'h8000_0014, 32'h0);
    check("unmapped_rd", dmem_ReadData, 32'h0);
    tick();
    drive(1'b0, A_STAT, 32'h0);
    check("stat_unmap_flag", dmem_ReadData, 32'h2);
    drive(1'b1, 32'h8000_001C, 32'hFF);
    tick();
    drive(1'b0, A_LED, 32'h0);
    check("unmapped_wr_ignored", dmem_ReadData, 32'h25);
    drive(1'b1, A_STAT, 32'h2);
    tick();
    drive(1'b0, A_STAT, 32'h0);
    check("stat_unmap_clear", dmem_ReadData, 32'h0);

    // ---------------- BTN synchronizer ----------------
    btn = 2'b10;
    drive(1'b0, A_BTN, 32'h0);
    check("btn_0cyc", dmem_ReadData, 32'h0);
    tick();
    check("btn_1cyc", dmem_ReadData, 32'h0);
    tick();
    check("btn_2cyc", dmem_ReadData, 32'h2);
    drive(1'b1, A_BTN, 32'h1);
    tick();
    drive(1'b0, A_BTN, 32'h0);
    check("btn_wr_ignored", dmem_ReadData, 32'h2);

    // ---------------- reset during a write ----------------
    rst = 1'b0;
    drive(1'b1, A_LED, 32'h3F);
    tick();
    check("rst_wr_led", {26'h0, led}, 32'h0);
    drive(1'b1, 32'h10, 32'h5555_5555);
    tick();
    drive(1'b0, 32'h10, 32'h0);
    check("rst_wr_ram_blocked", dmem_ReadData, 32'hDEAD_BEEF);
    drive(1'b0, A_CYCLE, 32'h0);
    check("rst_cycle", dmem_ReadData, 32'h0);
    drive(1'b0, A_CMP, 32'h0);
    check("rst_cmp", dmem_ReadData, TEN ? 32'hFFFF_FFFF : 32'h0);
    drive(1'b0, A_BTN, 32'h0);
    check("rst_btn_sync", dmem_ReadData, 32'h0);
    check("rst_irq_again", {31'h0, timer_irq}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
